// File: rtl/conv_controller_n_if.sv
// Handshake bundle between the host load strobes and the convolution controller.
// Ports: host strobes (sample_load_en, new_row, coeff_load_en) and
// controller status/control outputs (modwait, sample_stream, sample_shift,
// convolve_en, coeff_ld, coeff_sel, fill_count, coeff_valid).
// master = host side, slave = controller side.
interface conv_controller_n_if #(
  parameter int NUM_TAPS = 3
);
  localparam int SEL_W = $clog2(NUM_TAPS);
  localparam int CNT_W = $clog2(NUM_TAPS + 1);

  logic             sample_load_en;
  logic             new_row;
  logic             coeff_load_en;
  logic             modwait;
  logic             sample_stream;
  logic             sample_shift;
  logic             convolve_en;
  logic             coeff_ld;
  logic [SEL_W-1:0] coeff_sel;
  logic [CNT_W-1:0] fill_count;
  logic             coeff_valid;

  modport master (
    output sample_load_en, new_row, coeff_load_en,
    input  modwait, sample_stream, sample_shift, convolve_en,
    input  coeff_ld, coeff_sel, fill_count, coeff_valid
  );

  modport slave (
    input  sample_load_en, new_row, coeff_load_en,
    output modwait, sample_stream, sample_shift, convolve_en,
    output coeff_ld, coeff_sel, fill_count, coeff_valid
  );
endinterface

// File: rtl/conv_controller_n.sv
// NUM_TAPS-tap convolution sequencer: row fill, streaming MAC issue, row
// restart and coefficient burst loads, with priority coeff > new_row > sample.
// Ports: clk, rst (async active-high), bus (conv_controller_n_if.slave).
// Optional macro CONV_COEFF_GATE_EN: when defined, convolve_en is suppressed
// until a complete coefficient burst has been loaded (coeff_valid).
module conv_controller_n #(
  parameter int NUM_TAPS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_controller_n_if.slave   bus
);
  localparam int SEL_W = $clog2(NUM_TAPS);
  localparam int CNT_W = $clog2(NUM_TAPS + 1);
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NUM_TAPS);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FILL_LOAD  = 3'd1,
    FILL_WAIT  = 3'd2,
    CONVOLVE   = 3'd3,
    STREAM     = 3'd4,
    CONV_WAIT  = 3'd5,
    COEFF_LOAD = 3'd6
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] fill_cnt, fill_nxt;
  logic [SEL_W-1:0] coeff_idx, idx_nxt;
  logic             valid_q, valid_nxt;
  logic             conv_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fill_cnt  <= '0;
      coeff_idx <= '0;
      valid_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      fill_cnt  <= fill_nxt;
      coeff_idx <= idx_nxt;
      valid_q   <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    fill_nxt  = fill_cnt;
    idx_nxt   = coeff_idx;
    valid_nxt = valid_q;
    case (state)
      IDLE: begin
        if (bus.coeff_load_en) begin
          state_nxt = COEFF_LOAD;
          idx_nxt   = '0;
        end else if (bus.sample_load_en) begin
          state_nxt = FILL_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      FILL_LOAD: begin
        // Saturating: the window can never hold more than NUM_TAPS samples.
        if (fill_cnt < FULL_CNT) fill_nxt = fill_cnt + 1'b1;
        state_nxt = (fill_cnt == LAST_FILL) ? CONVOLVE : FILL_WAIT;
      end
      FILL_WAIT: begin
        // A partial fill is never interrupted; only the next sample matters.
        state_nxt = bus.sample_load_en ? FILL_LOAD : FILL_WAIT;
      end
      CONVOLVE, CONV_WAIT: begin
        if (bus.coeff_load_en) begin
          state_nxt = COEFF_LOAD;
          idx_nxt   = '0;
          fill_nxt  = '0;
        end else if (bus.new_row) begin
          // A sample arriving with new_row is the first of the new row.
          fill_nxt  = '0;
          state_nxt = bus.sample_load_en ? FILL_LOAD : FILL_WAIT;
        end else if (bus.sample_load_en) begin
          state_nxt = STREAM;
        end else begin
          state_nxt = CONV_WAIT;
        end
      end
      STREAM: begin
        state_nxt = CONVOLVE;
      end
      COEFF_LOAD: begin
        if (coeff_idx == LAST_SEL) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          valid_nxt = 1'b1;
        end else begin
          state_nxt = COEFF_LOAD;
          idx_nxt   = coeff_idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs: everything decodes from registered state and counters.
  always_comb begin
    bus.modwait       = 1'b0;
    bus.sample_stream = 1'b0;
    bus.sample_shift  = 1'b0;
    bus.coeff_ld      = 1'b0;
    bus.coeff_sel     = '0;
    conv_state        = 1'b0;
    case (state)
      FILL_LOAD, STREAM: begin
        bus.modwait      = 1'b1;
        bus.sample_shift = 1'b1;
      end
      CONVOLVE: begin
        conv_state        = 1'b1;
        bus.sample_stream = 1'b1;
      end
      CONV_WAIT: bus.sample_stream = 1'b1;
      COEFF_LOAD: begin
        bus.modwait   = 1'b1;
        bus.coeff_ld  = 1'b1;
        bus.coeff_sel = coeff_idx;
      end
      default: ;
    endcase
  end

`ifdef CONV_COEFF_GATE_EN
  assign bus.convolve_en = conv_state & valid_q;
`else
  assign bus.convolve_en = conv_state;
`endif

  assign bus.fill_count  = fill_cnt;
  assign bus.coeff_valid = valid_q;
endmodule

// File: doc/conv_controller_n.md
Name: conv_controller_n

Overview:
Parametrised successor to the 3-tap convolution sequencer, generalised to NUM_TAPS taps. It drives the sample shift register and coefficient register file, handling:
- initial row fill
- per-sample streaming convolution
- row restart
- burst coefficient loads

It sits between the host-side load-enable strobes and the convolution datapath. It adds fill/coefficient counters, a coefficient-valid flag and explicit event priority.

Parameters:
NUM_TAPS, 3, number of kernel taps / samples per window; legal range 2..16.
SEL_W, $clog2(NUM_TAPS), width of coeff_sel; derived, never overridden.
CNT_W, $clog2(NUM_TAPS+1), width of fill_count; derived.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
sample_load_en  input  1  one-cycle strobe: new sample present
new_row  input  1  level/strobe: start of new image row
coeff_load_en  input  1  one-cycle strobe: start coefficient burst
modwait  output  1  busy; high during every shift or coeff-load cycle
sample_stream  output  1  high in CONVOLVE and CONV_WAIT
sample_shift  output  1  shift sample register this cycle
convolve_en  output  1  compute MAC this cycle
coeff_ld  output  1  write coefficient register coeff_sel
coeff_sel  output  SEL_W  coefficient register index
fill_count  output  CNT_W  samples loaded in current row fill (0..NUM_TAPS)
coeff_valid  output  1  sticky: full coefficient burst completed since reset

Behaviour:
- Outputs are Moore, decoded from registered state and counters. rst forces: state IDLE, fill_count 0, coeff_idx 0, coeff_valid 0, all outputs 0. A rst mid-burst or mid-fill aborts immediately; no partial state survives.
- Event priority wherever multiple inputs are sampled: coeff_load_en > new_row > sample_load_en.
- IDLE (all outputs 0):
  - coeff_load_en -> COEFF_LOAD with coeff_idx=0.
  - else sample_load_en -> FILL_LOAD.
- FILL_LOAD (modwait=1, sample_shift=1):
  - fill_count increments.
  - If the pre-increment fill_count == NUM_TAPS-1 -> CONVOLVE, else -> FILL_WAIT.
  - Inputs are ignored.
- FILL_WAIT (outputs 0):
  - sample_load_en -> FILL_LOAD.
  - coeff_load_en and new_row are ignored; fill continues.
- CONVOLVE (convolve_en=1, sample_stream=1), exactly one cycle:
  - coeff_load_en -> COEFF_LOAD, fill_count cleared.
  - else new_row & sample_load_en -> FILL_LOAD, fill_count cleared to 0; this sample is the first of the new row.
  - else new_row -> FILL_WAIT, fill_count cleared.
  - else sample_load_en -> STREAM.
  - else -> CONV_WAIT.
- STREAM (modwait=1, sample_shift=1) -> CONVOLVE. fill_count holds at NUM_TAPS.
- CONV_WAIT (sample_stream=1): same transitions as CONVOLVE, except no event -> stay in CONV_WAIT.
- COEFF_LOAD (modwait=1, coeff_ld=1, coeff_sel=coeff_idx):
  - coeff_idx increments each cycle. The burst is exactly NUM_TAPS consecutive cycles, sel 0..NUM_TAPS-1.
  - On coeff_idx == NUM_TAPS-1: -> IDLE, coeff_idx=0, coeff_valid set to 1.
  - All inputs are ignored during the burst.
- Latency:
  - Sample strobe in CONV_WAIT -> shift asserted the next cycle -> convolve_en the cycle after (2 cycles).
  - Fill of N samples: the final shift cycle is followed immediately by convolve_en.
- fill_count never exceeds NUM_TAPS and does not wrap.
- coeff_sel is 0 outside COEFF_LOAD.
- Unused state encodings -> IDLE next cycle, all outputs 0.

Optional Feature:
Macro CONV_COEFF_GATE_EN.
- Defined: convolve_en is ANDed with coeff_valid, so no MAC is issued before the first complete coefficient burst. State transitions are unchanged.
- Undefined: convolve_en is driven purely by state; coeff_valid is still reported.

Test Plan:
1. Reset, NUM_TAPS=3: hold rst 2 cycles mid-COEFF_LOAD (sel=1) -> all outputs 0, coeff_valid=0, fill_count=0 on the first cycle rst is high.
2. NUM_TAPS=5, coeff_load_en pulse in IDLE -> coeff_ld high 5 consecutive cycles, coeff_sel 0,1,2,3,4, modwait high throughout, coeff_valid=1 from the 6th cycle.
3. NUM_TAPS=3, three sample_load_en strobes spaced 4 cycles apart:
   - sample_shift pulses 3 times; fill_count steps 1,2,3.
   - convolve_en is high the cycle after the 3rd shift, then sample_stream stays high in CONV_WAIT.
4. Streaming from CONV_WAIT, sample_load_en -> sample_shift next cycle, convolve_en the following cycle, fill_count stays 3.
5. In CONV_WAIT, assert new_row and sample_load_en together -> FILL_LOAD next cycle with fill_count 0->1. Then assert coeff_load_en together with new_row -> COEFF_LOAD wins, coeff_sel=0.
6. With CONV_COEFF_GATE_EN, fill 3 samples without any coefficient load -> sample_stream=1 but convolve_en stays 0. After a burst, the next fill gives convolve_en=1.
